// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encodings, divider iteration count, the divide-by-zero quotient and a
// magnitude helper used when latching divide operands.
package mdu_iter_pkg;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_MULT = 2'd1;
  localparam logic [1:0] MDU_DIV  = 2'd2;
  localparam logic [1:0] MDU_DONE = 2'd3;

  localparam int MDU_DIV_CYCLES = 32;

  localparam logic [31:0] MDU_DIV_ZERO_QUO = 32'hFFFF_FFFF;

  // Absolute value of a 32-bit operand when sgn=1, raw value otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_div_radix2_core.sv
// Radix-2 restoring divide datapath: 64-bit {rem,quo} shift-subtract
// register, iteration counter and a done flag that is high during the
// final iteration. quo/rem present the value the register takes at the
// next edge, so the owner can capture the final result on that same edge.
module div_radix2_core
  import mdu_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [63:0] acc_q;
  logic [63:0] acc_nxt;
  logic [31:0] dvs_q;
  logic [5:0]  count_q;
  logic        busy_q;
  logic [32:0] diff;

  // One iteration: shift left, trial-subtract with the bit shifted out of
  // rem kept as bit 32, keep the difference if it did not go negative.
  always_comb begin
    diff    = acc_q[63:31] - {1'b0, dvs_q};
    acc_nxt = {acc_q[62:0], 1'b0};
    if (!diff[32]) begin
      acc_nxt = {diff[31:0], acc_q[30:0], 1'b1};
    end
    done = busy_q && (count_q == 6'(MDU_DIV_CYCLES - 1));
    quo  = acc_nxt[31:0];
    rem  = acc_nxt[63:32];
  end

  // Iteration register and counter; clr abandons an in-flight divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (load) begin
      acc_q   <= {32'd0, dividend};
      dvs_q   <= divisor;
      count_q <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q   <= acc_nxt;
      count_q <= count_q + 6'd1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage. Produces the
// 64-bit {HI,LO} result and the stall that holds decode/execute while an
// operation is in flight. Optional build macro: MDU_EARLY_OUT_EN (divides
// with divisor magnitude 0 or larger than the dividend finish in one cycle).
//
// Handshake: start_mult/start_div are level requests from the decoder. A
// request is accepted only in IDLE without flush; stall rises the same
// cycle and stays high until the result cycle, where stall is low and
// result_valid pulses so the instruction retires with its result. Requests
// seen in any other state are ignored; upstream re-presents them.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int MULT_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        signed_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_zero,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state_q;
  logic [1:0]  mcnt_q;
  logic [31:0] ma_q, mb_q;
  logic        msgn_q;
  logic        q_sign_q, r_sign_q, dz_op_q;
  logic [31:0] raw_a_q;
  logic [31:0] hi_q, lo_q;
  logic        div_zero_q;

  logic        accept;
  logic        early;
  logic        core_load, core_done;
  logic [31:0] core_quo, core_rem;
  logic [31:0] mag_a, mag_b;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] quo_fix, rem_fix;
  logic        mult_last;

  // Request acceptance, stall, operand magnitudes and result shaping.
  always_comb begin
    accept       = (state_q == MDU_IDLE) && (start_mult || start_div) && !flush;
    stall        = accept || (state_q == MDU_MULT) || (state_q == MDU_DIV);
    result_valid = (state_q == MDU_DONE) && !flush;
    mag_a        = mag32(src_a, signed_op);
    mag_b        = mag32(src_b, signed_op);
`ifdef MDU_EARLY_OUT_EN
    early        = (mag_b == 32'd0) || (mag_b > mag_a);
`else
    early        = 1'b0;
`endif
    core_load    = accept && !start_mult && start_div && !early;
    ext_a        = msgn_q ? {{32{ma_q[31]}}, ma_q} : {32'd0, ma_q};
    ext_b        = msgn_q ? {{32{mb_q[31]}}, mb_q} : {32'd0, mb_q};
    product      = ext_a * ext_b;
    mult_last    = (mcnt_q == 2'(MULT_STAGES - 1));
    quo_fix      = q_sign_q ? (~core_quo + 32'd1) : core_quo;
    rem_fix      = r_sign_q ? (~core_rem + 32'd1) : core_rem;
    if (dz_op_q) begin
      quo_fix = MDU_DIV_ZERO_QUO;
      rem_fix = raw_a_q;
    end
  end

  div_radix2_core u_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .load     (core_load),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (core_done),
    .quo      (core_quo),
    .rem      (core_rem)
  );

  // Control FSM plus operand latches and the registered HI/LO result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MDU_IDLE;
      mcnt_q     <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      msgn_q     <= 1'b0;
      q_sign_q   <= 1'b0;
      r_sign_q   <= 1'b0;
      dz_op_q    <= 1'b0;
      raw_a_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else if (flush) begin
      state_q <= MDU_IDLE;
      mcnt_q  <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start_mult) begin
            ma_q    <= src_a;
            mb_q    <= src_b;
            msgn_q  <= signed_op;
            mcnt_q  <= '0;
            state_q <= MDU_MULT;
          end else if (start_div) begin
            q_sign_q <= signed_op && (src_a[31] ^ src_b[31]);
            r_sign_q <= signed_op && src_a[31];
            dz_op_q  <= (src_b == 32'd0);
            raw_a_q  <= src_a;
            if (early) begin
              hi_q       <= src_a;
              lo_q       <= (src_b == 32'd0) ? MDU_DIV_ZERO_QUO : 32'd0;
              div_zero_q <= (src_b == 32'd0);
              state_q    <= MDU_DONE;
            end else begin
              state_q <= MDU_DIV;
            end
          end
        end
        MDU_MULT: begin
          if (mult_last) begin
            hi_q       <= product[63:32];
            lo_q       <= product[31:0];
            div_zero_q <= 1'b0;
            state_q    <= MDU_DONE;
          end else begin
            mcnt_q <= mcnt_q + 2'd1;
          end
        end
        MDU_DIV: begin
          if (core_done) begin
            hi_q       <= rem_fix;
            lo_q       <= quo_fix;
            div_zero_q <= dz_op_q;
            state_q    <= MDU_DONE;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
        end
      endcase
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the execute stage.
- Consumes the decoder's mult/div control bits (ismult, signedmult, isdiv, signeddiv) and produces the 64-bit {HI,LO} result for the HI/LO register file.
- Drives the stall that holds decode and execute while an operation is in flight, so it is the responder end of the decoder's stall interface.
- Radix-2 restoring divider, DIV_CYCLES iterations; pipelined multiplier, MULT_STAGES cycles.

Parameters:
- MULT_STAGES, 1: cycles spent in state MULT; legal range 1-4.
- DIV_CYCLES, 32: divider iterations; fixed at the operand width, not for override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  exception/pipeline flush; cancels any in-flight operation.
- start_mult  input  1  ismult from the decoder, execute-stage copy.
- start_div  input  1  isdiv from the decoder, execute-stage copy.
- signed_op  input  1  signedmult or signeddiv; selects signed arithmetic.
- src_a  input  32  rs value: multiplicand / dividend.
- src_b  input  32  rt value: multiplier / divisor.
- stall  output  1  holds the upstream pipeline.
- result_valid  output  1  one-cycle pulse when hi_out/lo_out carry a new result.
- hi_out  output  32  product[63:32] / remainder.
- lo_out  output  32  product[31:0] / quotient.
- div_zero  output  1  divisor was zero; valid while result_valid is high.

Behaviour:
- Reset values: state IDLE; stall, result_valid, div_zero = 0; hi_out, lo_out = 0; counter = 0. Reset mid-operation aborts immediately, with no result_valid.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - start_mult=1 samples src_a, src_b and signed_op, then goes to MULT. start_mult has priority if both starts are high.
  - start_div=1 latches |src_a|, |src_b| (magnitudes only when signed_op=1), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]), then goes to DIV.
- stall is combinational:
  - High when (IDLE and (start_mult|start_div) and !flush), or when the state is MULT or DIV.
  - Low in DONE, so the instruction advances in the same cycle the result is valid.
- MULT: a counter runs MULT_STAGES cycles. The product is signed 64-bit when signed_op=1, else unsigned. Then go to DONE.
- DIV:
  - One iteration per cycle for 32 cycles.
  - Each iteration shifts the 64-bit {rem,quo} left by 1, subtracts the divisor from rem[63:32] (33-bit subtract), and sets the quotient bit if the result is non-negative.
  - After 32 iterations go to DONE. Sign fix-up is applied when the result is registered.
- Latency, with cycle 0 = start accepted in IDLE:
  - MULT: result_valid in cycle MULT_STAGES+1.
  - DIV: result_valid in cycle 33.
- DONE:
  - hi_out/lo_out are registered on entry to DONE; result_valid=1 for exactly one cycle; then return to IDLE.
  - hi_out/lo_out hold their value until the next DONE.
  - A start arriving in DONE is not accepted; it is accepted the following cycle in IDLE, because the upstream stage presents it again.
- Signed division:
  - Quotient is negated if the quotient sign is 1; remainder is negated if the remainder sign is 1.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Division by zero: lo = 0xFFFFFFFF, hi = src_a (raw), div_zero = 1. No sign fix-up. Full latency unless the optional feature is enabled.
- Starts while in MULT, DIV or DONE are ignored.
- flush in any state:
  - Next state is IDLE, with no result_valid. hi_out/lo_out are unchanged.
  - flush together with a start in IDLE: the start is not accepted.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- When defined: a divide with divisor magnitude 0 or greater than the dividend magnitude goes IDLE→DONE directly, so result_valid is in cycle 1.
  - Divisor > dividend gives quotient 0 and remainder = src_a.
  - Divisor = 0 gives the div-by-zero result above.
- When undefined: every divide takes the full 33 cycles.

Decomposition:
- defines.vh holds:
  - the state encodings (MDU_IDLE, MDU_MULT, MDU_DIV, MDU_DONE, 2-bit);
  - MDU_DIV_CYCLES = 32;
  - the div-by-zero quotient constant 32'hFFFFFFFF.
- One sub-module, div_radix2_core: the iteration datapath (shift-subtract register, 6-bit counter, done flag).
- Sign handling and the FSM stay in mdu_iter.

Test Plan:
1. Signed mult, src_a=7, src_b=0xFFFFFFFD, MULT_STAGES=1 → stall high in cycles 0-1; result_valid in cycle 2; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. Unsigned mult, src_a=src_b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
3. Unsigned div 100/7 → stall cycles 0-32; result_valid in cycle 33; lo=14, hi=2, div_zero=0.
4. Signed div 0xFFFFFFF9/2 (-7/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF; also 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
5. Div by zero, src_a=0x1234 → lo=0xFFFFFFFF, hi=0x1234, div_zero=1; result_valid in cycle 33, or in cycle 1 with MDU_EARLY_OUT_EN.
6. Start div, assert flush in cycle 10 → IDLE in cycle 11, stall low, no result_valid, hi/lo unchanged. Then start_mult in cycle 11 → correct result in cycle 13. Also: rst asserted mid-divide gives all outputs 0 asynchronously.
